// File: rtl/countdown_pkg.sv
// Shared types, constants and helpers for the BCD mm:ss countdown timer.
//   state_t    : controller states IDLE / RUN / PAUSE / DONE
//   bcd_valid  : checks a two-digit BCD byte for legal digits and an upper bound
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         DATA_W        = 16;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX  = 4'd5;
  localparam logic [7:0] BCD_SEC_MAX   = 8'h59;

  // With both digits legal, packed BCD bytes order the same way as their
  // decimal values, so a plain unsigned compare against max is exact.
  function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] max);
    return (val[7:4] <= BCD_DIGIT_MAX) && (val[3:0] <= BCD_DIGIT_MAX) && (val <= max);
  endfunction

  // Seconds additionally need a tens digit of 0..5.
  function automatic logic bcd_sec_valid(input logic [7:0] val);
    return bcd_valid(val, BCD_SEC_MAX) && (val[7:4] <= BCD_TENS_MAX);
  endfunction

endpackage

// File: rtl/bcd_pair_down.sv
// Two-digit BCD down counter with a configurable wrap value.
//   clk, rst_n : clock, asynchronous active-low reset (clears to 00)
//   load       : capture load_val (has priority over dec_en)
//   load_val   : BCD value to load
//   dec_en     : decrement by one; 00 wraps to WRAP
//   q          : current BCD value
//   borrow     : high while dec_en is applied to 00 (wrap in progress)
//   is_zero    : q == 00
module bcd_pair_down
  import countdown_pkg::*;
#(
  parameter logic [7:0] WRAP = 8'h59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec_en,
  output logic [7:0] q,
  output logic       borrow,
  output logic       is_zero
);

  assign is_zero = (q == 8'h00);
  assign borrow  = dec_en && is_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 8'h00;
    end else if (load) begin
      q <= load_val;
    end else if (dec_en) begin
      if (q[3:0] != 4'd0) begin
        q[3:0] <= q[3:0] - 4'd1;
      end else if (q[7:4] != 4'd0) begin
        q <= {q[7:4] - 4'd1, BCD_DIGIT_MAX};
      end else begin
        q <= WRAP;
      end
    end
  end

endmodule

// File: rtl/countdown_mmss.sv
// BCD minutes:seconds countdown timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   ld, data   : load request and BCD value {min_tens,min_units,sec_tens,sec_units}
//   start      : start / resume counting
//   pause      : suspend counting
//   tick       : one-cycle decrement strobe (1 Hz prescaler)
//   qout       : current mm:ss value, same packing as data
//   busy       : high while running or paused
//   done       : one-cycle pulse when the count reaches 00:00
//   bw         : one-cycle pulse when seconds wrap 00 -> 59
//   err        : one-cycle pulse when a load value is rejected
// Input priority each cycle: ld > pause > start > tick.
module countdown_mmss
  import countdown_pkg::*;
#(
  parameter logic [7:0] MIN_MAX = 8'h59
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic [DATA_W-1:0] data,
  input  logic              start,
  input  logic              pause,
  input  logic              tick,
  output logic [DATA_W-1:0] qout,
  output logic              busy,
  output logic              done,
  output logic              bw,
  output logic              err
);

  state_t     state_q, state_d;
  logic       load_ok, load_en, sec_dec;
  logic       done_d, err_d, busy_d;
  logic       sec_borrow, sec_zero, min_zero, min_borrow_unused;
  logic [7:0] sec_q, min_q;
  logic       count_zero, last_tick;

  assign qout       = {min_q, sec_q};
  assign load_ok    = bcd_valid(data[15:8], MIN_MAX) && bcd_sec_valid(data[7:0]);
  assign count_zero = sec_zero && min_zero;
  // The decrement that lands on 00:00 starts from 00:01; this is the only
  // way to finish, so minutes never borrow from 00.
  assign last_tick  = min_zero && (sec_q == 8'h01);

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    sec_dec = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (ld) begin
      if (load_ok) begin
        load_en = 1'b1;
        state_d = IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (count_zero) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick) begin
            sec_dec = 1'b1;
            if (last_tick) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (start) state_d = RUN;
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN) || (state_d == PAUSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bw      <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      bw      <= sec_borrow;
      err     <= err_d;
    end
  end

  bcd_pair_down #(.WRAP(BCD_SEC_MAX)) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_en),
    .load_val (data[7:0]),
    .dec_en   (sec_dec),
    .q        (sec_q),
    .borrow   (sec_borrow),
    .is_zero  (sec_zero)
  );

  bcd_pair_down #(.WRAP(BCD_SEC_MAX)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_en),
    .load_val (data[15:8]),
    .dec_en   (sec_borrow),
    .q        (min_q),
    .borrow   (min_borrow_unused),
    .is_zero  (min_zero)
  );

endmodule

// File: tb/tb_countdown_mmss.sv
module tb_countdown_mmss;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ld = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] qout;
  logic        busy, done, bw, err;

  int checks = 0;
  int errors = 0;

  countdown_mmss dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ld),
    .data  (data),
    .start (start),
    .pause (pause),
    .tick  (tick),
    .qout  (qout),
    .busy  (busy),
    .done  (done),
    .bw    (bw),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Model: remaining time kept as plain seconds, converted to BCD on output.
  function automatic logic load_valid(input logic [15:0] d);
    int mt, mu, st, su;
    mt = int'(d[15:12]); mu = int'(d[11:8]); st = int'(d[7:4]); su = int'(d[3:0]);
    return (mt <= 9) && (mu <= 9) && (st <= 5) && (su <= 9) && ((mt * 10 + mu) <= 59);
  endfunction

  function automatic int to_secs(input logic [15:0] d);
    return (int'(d[15:12]) * 10 + int'(d[11:8])) * 60 + int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  function automatic logic [15:0] to_bcd(input int total);
    int mm, ss;
    mm = total / 60;
    ss = total % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  int   m_total = 0, n_total;
  int   m_mode = M_IDLE, n_mode;
  logic e_done = 1'b0, e_bw = 1'b0, e_err = 1'b0;
  logic n_done, n_bw, n_err;

  always_comb begin
    n_total = m_total;
    n_mode  = m_mode;
    n_done  = 1'b0;
    n_bw    = 1'b0;
    n_err   = 1'b0;
    if (ld) begin
      if (load_valid(data)) begin
        n_total = to_secs(data);
        n_mode  = M_IDLE;
      end else begin
        n_err = 1'b1;
      end
    end else if (m_mode == M_IDLE && start) begin
      if (m_total == 0) begin
        n_mode = M_DONE;
        n_done = 1'b1;
      end else begin
        n_mode = M_RUN;
      end
    end else if (m_mode == M_RUN && pause) begin
      n_mode = M_PAUSE;
    end else if (m_mode == M_RUN && tick) begin
      n_bw    = (m_total % 60 == 0);
      n_total = m_total - 1;
      if (n_total == 0) begin
        n_mode = M_DONE;
        n_done = 1'b1;
      end
    end else if (m_mode == M_PAUSE && start) begin
      n_mode = M_RUN;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_total <= 0;
      m_mode  <= M_IDLE;
      e_done  <= 1'b0;
      e_bw    <= 1'b0;
      e_err   <= 1'b0;
    end else begin
      m_total <= n_total;
      m_mode  <= n_mode;
      e_done  <= n_done;
      e_bw    <= n_bw;
      e_err   <= n_err;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("m_qout", qout, to_bcd(m_total));
    chk("m_busy", 16'(busy), 16'(m_mode == M_RUN || m_mode == M_PAUSE));
    chk("m_done", 16'(done), 16'(e_done));
    chk("m_bw",   16'(bw),   16'(e_bw));
    chk("m_err",  16'(err),  16'(e_err));
  end

  task automatic cyc(input logic l, input logic [15:0] d, input logic s,
                     input logic p, input logic t);
    @(negedge clk);
    ld = l; data = d; start = s; pause = p; tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_qout", qout, 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: 01:02 counting through a minute borrow
    cyc(1'b1, 16'h0102, 1'b0, 1'b0, 1'b0);
    chk("t1_load", qout, 16'h0102);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("t1_busy", 16'(busy), 16'h1);
    chk("t1_nodec", qout, 16'h0102);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t1_q1", qout, 16'h0101);
    chk("t1_bw1", 16'(bw), 16'h0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t1_q2", qout, 16'h0100);
    chk("t1_bw2", 16'(bw), 16'h0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t1_q3", qout, 16'h0059);
    chk("t1_bw3", 16'(bw), 16'h1);
    chk("t1_busy3", 16'(busy), 16'h1);
    idle();
    chk("t1_bw_off", 16'(bw), 16'h0);

    // 2: finish at 00:00
    cyc(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t2_q1", qout, 16'h0001);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t2_q0", qout, 16'h0000);
    chk("t2_done", 16'(done), 16'h1);
    chk("t2_busy", 16'(busy), 16'h0);
    chk("t2_bw", 16'(bw), 16'h0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t2_done_off", 16'(done), 16'h0);
    chk("t2_hold", qout, 16'h0000);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("t2_restart", 16'(done), 16'h0);

    // 3: rejected loads
    cyc(1'b1, 16'h0047, 1'b0, 1'b0, 1'b0);
    chk("t3_load", qout, 16'h0047);
    chk("t3_err0", 16'(err), 16'h0);
    cyc(1'b1, 16'h0170, 1'b0, 1'b0, 1'b0);
    chk("t3_err1", 16'(err), 16'h1);
    chk("t3_keep1", qout, 16'h0047);
    idle();
    chk("t3_err_off", 16'(err), 16'h0);
    cyc(1'b1, 16'h6000, 1'b0, 1'b0, 1'b0);
    chk("t3_err2", 16'(err), 16'h1);
    chk("t3_keep2", qout, 16'h0047);
    cyc(1'b1, 16'h0060, 1'b0, 1'b0, 1'b0);
    chk("t3_err3", 16'(err), 16'h1);
    cyc(1'b1, 16'h5959, 1'b0, 1'b0, 1'b0);
    chk("t3_max", qout, 16'h5959);
    chk("t3_max_err", 16'(err), 16'h0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t3_max_dec", qout, 16'h5958);

    // 4: pause / resume
    cyc(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    chk("t4_idle", 16'(busy), 16'h0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t4_q9", qout, 16'h0009);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t4_held", qout, 16'h0009);
    chk("t4_busy", 16'(busy), 16'h1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("t4_resume", qout, 16'h0009);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t4_q8", qout, 16'h0008);

    // 5: asynchronous reset mid-run
    cyc(1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t5_q29", qout, 16'h0029);
    @(negedge clk);
    ld = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_q", qout, 16'h0000);
    chk("t5_rst_busy", 16'(busy), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("t5_done", 16'(done), 16'h1);
    chk("t5_busy", 16'(busy), 16'h0);

    // 6: load wins over start; start with tick does not decrement
    cyc(1'b1, 16'h0005, 1'b1, 1'b0, 1'b0);
    chk("t6_q", qout, 16'h0005);
    chk("t6_busy0", 16'(busy), 16'h0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("t6_busy1", 16'(busy), 16'h1);
    chk("t6_nodec", qout, 16'h0005);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    chk("t6_q4", qout, 16'h0004);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
